// File: rtl/mux4_pkg.sv
// Shared types and constants for the registered 4:1 word mux.
// Select encoding below is relied on by mux4_core and mux4.
package mux4_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0 = 2'b00;
  localparam sel_t SEL_D1 = 2'b01;
  localparam sel_t SEL_D2 = 2'b10;
  localparam sel_t SEL_D3 = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// Combinational WIDTH-bit 4:1 select; an unknown select yields all-X
// in simulation rather than falling through to d0.
module mux4_core
  import mux4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  sel_t             s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (s)
      SEL_D0:  y = d0;
      SEL_D1:  y = d1;
      SEL_D2:  y = d2;
      SEL_D3:  y = d3;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux4.sv
// Registered 4:1 word mux, one cycle latency, sync active-high reset.
// Optional even-parity output y_par when MUX4_PARITY_EN is defined.
module mux4
  import mux4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  sel_t             s,
  output logic [WIDTH-1:0] y
`ifdef MUX4_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] sel_y;

  mux4_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .s (s),
    .y (sel_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      y <= '0;
    end else begin
      y <= sel_y;
    end
  end

`ifdef MUX4_PARITY_EN
  // y_par makes {y, y_par} even parity
  always_ff @(posedge clk) begin
    if (reset) begin
      y_par <= 1'b0;
    end else begin
      y_par <= ^sel_y;
    end
  end
`endif

endmodule

// File: tb/tb_mux4.sv
// Directed bench for mux4: vector table plus hand sequences
// for mid-cycle input changes and a WIDTH=16 instance.
module tb_mux4;
  import mux4_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] d0, d1, d2, d3;
  sel_t       s;
  logic [7:0] y;
`ifdef MUX4_PARITY_EN
  logic       y_par;
`endif

  logic [15:0] w0, w1, w2, w3;
  sel_t        ws;
  logic [15:0] wy;
`ifdef MUX4_PARITY_EN
  logic        wy_par;
`endif

  int tests;
  int fails;

  mux4 #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .d0   (d0),
    .d1   (d1),
    .d2   (d2),
    .d3   (d3),
    .s    (s),
    .y    (y)
`ifdef MUX4_PARITY_EN
    ,
    .y_par(y_par)
`endif
  );

  mux4 #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .reset(reset),
    .d0   (w0),
    .d1   (w1),
    .d2   (w2),
    .d3   (w3),
    .s    (ws),
    .y    (wy)
`ifdef MUX4_PARITY_EN
    ,
    .y_par(wy_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    sel_t       sel;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] exp_y;
    logic       exp_p;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst;
    s     = v.sel;
    d0    = v.a0;
    d1    = v.a1;
    d2    = v.a2;
    d3    = v.a3;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    s  = SEL_D1;
    d0 = 8'h33; d1 = 8'h43; d2 = 8'hAD; d3 = 8'hAF;
    ws = SEL_D3;
    w0 = 16'h1234; w1 = 16'h0000; w2 = 16'h0000; w3 = 16'hBEEF;

    vecs[0]  = '{1'b1, SEL_D1, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, SEL_D1, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, SEL_D1, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'h43, 1'b1};
    vecs[3]  = '{1'b0, SEL_D0, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'h33, 1'b0};
    vecs[4]  = '{1'b0, SEL_D1, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'h43, 1'b1};
    vecs[5]  = '{1'b0, SEL_D2, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'hAD, 1'b1};
    vecs[6]  = '{1'b0, SEL_D3, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'hAF, 1'b0};
    vecs[7]  = '{1'b1, SEL_D3, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, SEL_D3, 8'h33, 8'h43, 8'hAD, 8'hAF, 8'hAF, 1'b0};
    vecs[9]  = '{1'b0, SEL_D2, 8'hFF, 8'hFF, 8'hAD, 8'hFF, 8'hAD, 1'b1};
    vecs[10] = '{1'b0, SEL_D1, 8'h33, 8'h0F, 8'hAD, 8'hAF, 8'h0F, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_y", i), {8'h00, y}, {8'h00, vecs[i].exp_y});
`ifdef MUX4_PARITY_EN
      check($sformatf("vec%0d_par", i), {15'h0, y_par},
            {15'h0, vecs[i].exp_p});
`endif
      @(negedge clk);
    end

    // select d2, then alter d2 between edges: y must hold until next edge
    s = SEL_D2;
    d2 = 8'hAD;
    @(posedge clk);
    #1;
    check("hold_pre", {8'h00, y}, 16'h00AD);
    d2 = 8'h5A;
    d0 = 8'h00; d1 = 8'hC3; d3 = 8'h81;
    #2;
    check("hold_mid", {8'h00, y}, 16'h00AD);
    @(negedge clk);
    check("hold_neg", {8'h00, y}, 16'h00AD);
    @(posedge clk);
    #1;
    check("d2_new", {8'h00, y}, 16'h005A);
`ifdef MUX4_PARITY_EN
    check("d2_new_par", {15'h0, y_par}, 16'h0000);
`endif
    d0 = 8'h11; d1 = 8'h22; d3 = 8'h44;
    @(posedge clk);
    #1;
    check("unsel_chg", {8'h00, y}, 16'h005A);

    // one-cycle lag with unchanged inputs across the edge
    @(negedge clk);
    s = SEL_D3;
    #1;
    check("no_comb", {8'h00, y}, 16'h005A);
    @(posedge clk);
    #1;
    check("lag_d3", {8'h00, y}, 16'h0044);

    check("w16_d3", wy, 16'hBEEF);
    @(negedge clk);
    ws = SEL_D0;
    @(posedge clk);
    #1;
    check("w16_d0", wy, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
